// File: rtl/decoder_3to8_seq.sv
// -----------------------------------------------------------------------------
// decoder_3to8_seq
//
// Registered 3-to-8 decoder. A 3-bit code {A2,A1,A0} is sampled on a valid
// strobe and the matching one-hot output Dn is held high for PULSE_LEN cycles.
// After the pulse, GAP_LEN idle cycles are enforced before another code is
// accepted. Codes that arrive while busy, or while en is low, are dropped and
// counted in a saturating 8-bit counter.
//
// Optional feature macro: DECODER_PARITY_EN
//   When defined, adds the even-parity input P and the err output. A code
//   whose parity check fails is rejected with a one-cycle err pulse.
//
// Parameters:
//   PULSE_LEN  cycles the selected Dn stays high (1..255)
//   GAP_LEN    idle cycles after a pulse before the next accept (0..255)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         block enable; low aborts a pulse or gap in progress
//   valid      code strobe
//   A2,A1,A0   code bits, A2 is the MSB
//   P          even-parity bit over A2..A0 (DECODER_PARITY_EN only)
//   D0..D7     one-hot decoded strobes, registered
//   busy       high from the accept edge until the end of the gap
//   done       one-cycle pulse when a pulse completes normally
//   drop_cnt   saturating count of dropped codes
//   err        one-cycle parity-error flag (DECODER_PARITY_EN only)
// -----------------------------------------------------------------------------
module decoder_3to8_seq #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       valid,
    input  logic       A2,
    input  logic       A1,
    input  logic       A0,
`ifdef DECODER_PARITY_EN
    input  logic       P,
    output logic       err,
`endif
    output logic       D0,
    output logic       D1,
    output logic       D2,
    output logic       D3,
    output logic       D4,
    output logic       D5,
    output logic       D6,
    output logic       D7,
    output logic       busy,
    output logic       done,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // The counter is loaded with length-1 so that the edge seeing zero is the
    // last edge of the phase.
    localparam logic [7:0] PULSE_RELOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_RELOAD   = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dout_q, dout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] drop_q, drop_d;
`ifdef DECODER_PARITY_EN
    logic       err_q, err_d;
`endif

    logic [2:0] code;
    logic [7:0] code_onehot;

    assign code = {A2, A1, A0};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_decode
            assign code_onehot[gi] = (code == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drop_d  = drop_q;
`ifdef DECODER_PARITY_EN
        err_d   = 1'b0;
`endif

        // Any strobe that cannot be accepted this edge is a drop; this
        // includes the completing edge of a gap, since state is not yet IDLE.
        if (valid && ((state_q != ST_IDLE) || !en) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (valid && en) begin
`ifdef DECODER_PARITY_EN
                    if (^{code, P}) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_PULSE;
                        dout_d  = code_onehot;
                        busy_d  = 1'b1;
                        cnt_d   = PULSE_RELOAD;
                    end
`else
                    state_d = ST_PULSE;
                    dout_d  = code_onehot;
                    busy_d  = 1'b1;
                    cnt_d   = PULSE_RELOAD;
`endif
                end
            end

            ST_PULSE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    dout_d  = 8'd0;
                    busy_d  = 1'b0;
                end else if (cnt_q == 8'd0) begin
                    dout_d = 8'd0;
                    done_d = 1'b1;
                    if (GAP_LEN == 0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_GAP: begin
                dout_d = 8'd0;
                if (!en || (cnt_q == 8'd0)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dout_d  = 8'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            dout_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 8'd0;
`ifdef DECODER_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
`ifdef DECODER_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end

    assign D0       = dout_q[0];
    assign D1       = dout_q[1];
    assign D2       = dout_q[2];
    assign D3       = dout_q[3];
    assign D4       = dout_q[4];
    assign D5       = dout_q[5];
    assign D6       = dout_q[6];
    assign D7       = dout_q[7];
    assign busy     = busy_q;
    assign done     = done_q;
    assign drop_cnt = drop_q;
`ifdef DECODER_PARITY_EN
    assign err      = err_q;
`endif

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// -----------------------------------------------------------------------------
// tb_decoder_3to8_seq
//
// Directed testbench for decoder_3to8_seq with PULSE_LEN=4, GAP_LEN=1.
// Inputs change 1 time unit after each rising edge; outputs are checked at the
// same point, so each check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_decoder_3to8_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       valid;
    logic       A2, A1, A0;
    logic       D0, D1, D2, D3, D4, D5, D6, D7;
    logic       busy;
    logic       done;
    logic [7:0] drop_cnt;
`ifdef DECODER_PARITY_EN
    logic       P;
    logic       err;
`endif

    int checks;
    int errors;

    logic [7:0] d_vec;
    assign d_vec = {D7, D6, D5, D4, D3, D2, D1, D0};

    decoder_3to8_seq #(
        .PULSE_LEN(4),
        .GAP_LEN  (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .valid   (valid),
        .A2      (A2),
        .A1      (A1),
        .A0      (A0),
`ifdef DECODER_PARITY_EN
        .P       (P),
        .err     (err),
`endif
        .D0      (D0),
        .D1      (D1),
        .D2      (D2),
        .D3      (D3),
        .D4      (D4),
        .D5      (D5),
        .D6      (D6),
        .D7      (D7),
        .busy    (busy),
        .done    (done),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a code with correct even parity (parity builds only).
    task automatic set_code(input logic [2:0] c);
        {A2, A1, A0} = c;
`ifdef DECODER_PARITY_EN
        P = ^c;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (d_vec !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_held: D=%b busy=%b done=%b drop=%0d, required D=0 busy=0 done=0 drop=0",
                     d_vec, busy, done, drop_cnt);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (d_vec !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: D=%b busy=%b done=%b drop=%0d, required all zero",
                     d_vec, busy, done, drop_cnt);
        end
        $display("reset: checked outputs during and after reset");
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        for (int c = 0; c < 8; c++) begin
            exp = 8'd1 << c;
            set_code(3'(c));
            valid = 1'b1;
            step();
            valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (d_vec !== exp || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_pulse code=%0d cyc=%0d: D=%b busy=%b done=%b, required D=%b busy=1 done=0",
                             c, i, d_vec, busy, done, exp);
                end
                step();
            end
            checks++;
            if (d_vec !== 8'd0 || busy !== 1'b1 || done !== 1'b1) begin
                errors++;
                $display("FAIL sweep_done code=%0d: D=%b busy=%b done=%b, required D=0 busy=1 done=1",
                         c, d_vec, busy, done);
            end
            step();
            checks++;
            if (d_vec !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL sweep_idle code=%0d: D=%b busy=%b done=%b, required all zero",
                         c, d_vec, busy, done);
            end
            $display("sweep: code %0d -> D=%b for 4 cycles", c, exp);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL sweep_drops: drop_cnt=%0d, required 0", drop_cnt);
        end
    endtask

    task automatic test_drop();
        set_code(3'd3);
        valid = 1'b1;
        step();
        set_code(3'd5);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (d_vec !== 8'h08) begin
                errors++;
                $display("FAIL drop_hold cyc=%0d: D=%b, required 00001000", i, d_vec);
            end
        end
        valid = 1'b0;
        step();
        checks++;
        if (d_vec !== 8'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL drop_done: D=%b done=%b, required D=0 done=1", d_vec, done);
        end
        step();
        checks++;
        if (drop_cnt !== 8'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_count: drop_cnt=%0d busy=%b, required 3 and 0", drop_cnt, busy);
        end
        $display("drop: code 3 pulsed, 3 strobes of code 5 dropped, drop_cnt=%0d", drop_cnt);
    endtask

    task automatic test_abort();
        set_code(3'd6);
        valid = 1'b1;
        step();
        valid = 1'b0;
        checks++;
        if (d_vec !== 8'h40) begin
            errors++;
            $display("FAIL abort_start: D=%b, required 01000000", d_vec);
        end
        step();
        en = 1'b0;
        step();
        checks++;
        if (d_vec !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: D=%b busy=%b done=%b, required all zero", d_vec, busy, done);
        end
        en = 1'b1;
        set_code(3'd1);
        valid = 1'b1;
        step();
        valid = 1'b0;
        checks++;
        if (d_vec !== 8'h02 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_next: D=%b busy=%b done=%b, required D=00000010 busy=1 done=0",
                     d_vec, busy, done);
        end
        repeat (5) step();
        checks++;
        if (busy !== 1'b0 || drop_cnt !== 8'd3) begin
            errors++;
            $display("FAIL abort_end: busy=%b drop_cnt=%0d, required 0 and 3", busy, drop_cnt);
        end
        $display("abort: code 6 aborted, code 1 accepted next cycle");
    endtask

    task automatic test_gap_boundary();
        set_code(3'd0);
        valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (4) step();
        set_code(3'd4);
        valid = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || d_vec !== 8'd0 || drop_cnt !== 8'd4) begin
            errors++;
            $display("FAIL gap_edge_drop: busy=%b D=%b drop_cnt=%0d, required 0, 0, 4",
                     busy, d_vec, drop_cnt);
        end
        step();
        valid = 1'b0;
        checks++;
        if (d_vec !== 8'h10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_next_accept: D=%b busy=%b, required 00010000 and 1", d_vec, busy);
        end
        repeat (5) step();
        checks++;
        if (busy !== 1'b0 || drop_cnt !== 8'd4) begin
            errors++;
            $display("FAIL gap_end: busy=%b drop_cnt=%0d, required 0 and 4", busy, drop_cnt);
        end
        $display("gap_boundary: strobe at gap end dropped, next edge accepted");
    endtask

    task automatic test_saturation();
        en = 1'b0;
        valid = 1'b1;
        set_code(3'd2);
        repeat (250) step();
        checks++;
        if (drop_cnt !== 8'd254) begin
            errors++;
            $display("FAIL sat_254: drop_cnt=%0d, required 254", drop_cnt);
        end
        step();
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_255: drop_cnt=%0d, required 255", drop_cnt);
        end
        repeat (49) step();
        checks++;
        if (drop_cnt !== 8'd255 || d_vec !== 8'd0) begin
            errors++;
            $display("FAIL sat_hold: drop_cnt=%0d D=%b, required 255 and 0", drop_cnt, d_vec);
        end
        valid = 1'b0;
        en = 1'b1;
        step();
        $display("saturation: 300 dropped strobes, drop_cnt=%0d", drop_cnt);
    endtask

    task automatic test_reset_mid_pulse();
        set_code(3'd2);
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d_vec !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: D=%b busy=%b done=%b drop=%0d, required all zero",
                     d_vec, busy, done, drop_cnt);
        end
        step();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (done !== 1'b0 || d_vec !== 8'd0) begin
                errors++;
                $display("FAIL reset_mid_after: D=%b done=%b, required 0 and 0", d_vec, done);
            end
        end
        $display("reset_mid_pulse: outputs cleared asynchronously");
    endtask

`ifdef DECODER_PARITY_EN
    task automatic test_parity();
        {A2, A1, A0} = 3'd7;
        P = 1'b0;
        valid = 1'b1;
        step();
        valid = 1'b0;
        checks++;
        if (err !== 1'b1 || d_vec !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad: err=%b D=%b busy=%b, required 1, 0, 0", err, d_vec, busy);
        end
        step();
        checks++;
        if (err !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL parity_bad_clear: err=%b drop_cnt=%0d, required 0 and 0", err, drop_cnt);
        end
        P = 1'b1;
        valid = 1'b1;
        step();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (d_vec !== 8'h80 || err !== 1'b0) begin
                errors++;
                $display("FAIL parity_good cyc=%0d: D=%b err=%b, required 10000000 and 0", i, d_vec, err);
            end
            step();
        end
        checks++;
        if (d_vec !== 8'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL parity_good_done: D=%b done=%b, required 0 and 1", d_vec, done);
        end
        step();
        $display("parity: bad parity rejected, good parity pulsed D7");
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        valid  = 1'b0;
        {A2, A1, A0} = 3'd0;
`ifdef DECODER_PARITY_EN
        P = 1'b0;
`endif
        #1;
        test_reset();
        test_sweep();
        test_drop();
        test_abort();
        test_gap_boundary();
        test_saturation();
        test_reset_mid_pulse();
`ifdef DECODER_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
